// File: rtl/bitty_pkg.sv
// Shared types and encodings for the bitty execute core: FSM states, instruction formats,
// ALU select codes (74181-style table) and the add-class decode used for carry generation.
package bitty_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StExec, StWb} state_e;

    localparam logic [1:0] FMT_REG = 2'b00;
    localparam logic [1:0] FMT_IMM = 2'b01;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // Arithmetic mode (mode 0), no carry-in.
    localparam logic [3:0] ARI_A             = 4'b0000;
    localparam logic [3:0] ARI_A_OR_B        = 4'b0001;
    localparam logic [3:0] ARI_A_OR_NB       = 4'b0010;
    localparam logic [3:0] ARI_MINUS1        = 4'b0011;
    localparam logic [3:0] ARI_A_ADD_A_NB    = 4'b0100;
    localparam logic [3:0] ARI_AOB_ADD_A_NB  = 4'b0101;
    localparam logic [3:0] ARI_A_SUB_B_DEC   = 4'b0110;
    localparam logic [3:0] ARI_A_NB_DEC      = 4'b0111;
    localparam logic [3:0] ARI_A_ADD_AB      = 4'b1000;
    localparam logic [3:0] ARI_A_ADD_B       = 4'b1001;
    localparam logic [3:0] ARI_AONB_ADD_AB   = 4'b1010;
    localparam logic [3:0] ARI_AB_DEC        = 4'b1011;
    localparam logic [3:0] ARI_A_ADD_A       = 4'b1100;
    localparam logic [3:0] ARI_AOB_ADD_A     = 4'b1101;
    localparam logic [3:0] ARI_AONB_ADD_A    = 4'b1110;
    localparam logic [3:0] ARI_A_DEC         = 4'b1111;

    // Logic mode (mode 1), carry always 0.
    localparam logic [3:0] LOG_NOT_A         = 4'b0000;
    localparam logic [3:0] LOG_NOR           = 4'b0001;
    localparam logic [3:0] LOG_NA_AND_B      = 4'b0010;
    localparam logic [3:0] LOG_ZERO          = 4'b0011;
    localparam logic [3:0] LOG_NAND          = 4'b0100;
    localparam logic [3:0] LOG_NOT_B         = 4'b0101;
    localparam logic [3:0] LOG_XOR           = 4'b0110;
    localparam logic [3:0] LOG_A_AND_NB      = 4'b0111;
    localparam logic [3:0] LOG_NA_OR_B       = 4'b1000;
    localparam logic [3:0] LOG_XNOR          = 4'b1001;
    localparam logic [3:0] LOG_B             = 4'b1010;
    localparam logic [3:0] LOG_AND           = 4'b1011;
    localparam logic [3:0] LOG_ONES          = 4'b1100;
    localparam logic [3:0] LOG_A_OR_NB       = 4'b1101;
    localparam logic [3:0] LOG_OR            = 4'b1110;
    localparam logic [3:0] LOG_A             = 4'b1111;

    // Codes whose result is a true two-operand sum; only these report a carry.
    function automatic logic is_add_class(input logic [3:0] sel);
        case (sel)
            ARI_A_ADD_A_NB, ARI_AOB_ADD_A_NB, ARI_A_ADD_AB, ARI_A_ADD_B,
            ARI_AONB_ADD_AB, ARI_A_ADD_A, ARI_AOB_ADD_A, ARI_AONB_ADD_A: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bitty_alu.sv
// Combinational bitty ALU: every arithmetic code is expressed as one sum p + q so a single
// adder serves all of them; logic codes bypass the adder.
module bitty_alu
    import bitty_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        sel,
    input  logic              mode,
    output logic [DATA_W-1:0] y,
    output logic              carry,
    output logic              eq
);

    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] q;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] logic_y;

    // Decrement codes add all-ones; subtraction adds ~B.
    always_comb begin
        p = a;
        q = '0;
        unique case (sel)
            ARI_A:            begin p = a;          q = '0;      end
            ARI_A_OR_B:       begin p = a | b;      q = '0;      end
            ARI_A_OR_NB:      begin p = a | ~b;     q = '0;      end
            ARI_MINUS1:       begin p = '0;         q = '1;      end
            ARI_A_ADD_A_NB:   begin p = a;          q = a & ~b;  end
            ARI_AOB_ADD_A_NB: begin p = a | b;      q = a & ~b;  end
            ARI_A_SUB_B_DEC:  begin p = a;          q = ~b;      end
            ARI_A_NB_DEC:     begin p = a & ~b;     q = '1;      end
            ARI_A_ADD_AB:     begin p = a;          q = a & b;   end
            ARI_A_ADD_B:      begin p = a;          q = b;       end
            ARI_AONB_ADD_AB:  begin p = a | ~b;     q = a & b;   end
            ARI_AB_DEC:       begin p = a & b;      q = '1;      end
            ARI_A_ADD_A:      begin p = a;          q = a;       end
            ARI_AOB_ADD_A:    begin p = a | b;      q = a;       end
            ARI_AONB_ADD_A:   begin p = a | ~b;     q = a;       end
            ARI_A_DEC:        begin p = a;          q = '1;      end
        endcase
    end

    assign sum = {1'b0, p} + {1'b0, q};

    always_comb begin
        logic_y = a;
        unique case (sel)
            LOG_NOT_A:    logic_y = ~a;
            LOG_NOR:      logic_y = ~(a | b);
            LOG_NA_AND_B: logic_y = ~a & b;
            LOG_ZERO:     logic_y = '0;
            LOG_NAND:     logic_y = ~(a & b);
            LOG_NOT_B:    logic_y = ~b;
            LOG_XOR:      logic_y = a ^ b;
            LOG_A_AND_NB: logic_y = a & ~b;
            LOG_NA_OR_B:  logic_y = ~a | b;
            LOG_XNOR:     logic_y = ~(a ^ b);
            LOG_B:        logic_y = b;
            LOG_AND:      logic_y = a & b;
            LOG_ONES:     logic_y = '1;
            LOG_A_OR_NB:  logic_y = a | ~b;
            LOG_OR:       logic_y = a | b;
            LOG_A:        logic_y = a;
        endcase
    end

    assign y     = (mode == MODE_LOGIC) ? logic_y : sum[DATA_W-1:0];
    assign carry = (mode == MODE_ARITH) && is_add_class(sel) && sum[DATA_W];
    assign eq    = (a == b);

endmodule

// File: rtl/bitty_exec_core.sv
// Multi-cycle bitty execute core: register file, S/C latches and the IDLE/LOAD/EXEC/WB FSM.
// Define BITTY_IMM_EN to execute fmt 01 as register-immediate; otherwise fmt 01 is illegal.
module bitty_exec_core
    import bitty_pkg::*;
#(
    parameter  int unsigned DATA_W   = 16,
    parameter  int unsigned NUM_REGS = 8,
    localparam int unsigned REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       instr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_eq,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    state_e            state_q, state_d;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] s_q, c_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              done_q, err_q, flag_c_q, flag_z_q, flag_eq_q;

    logic              accept, ld_ok, fmt_legal;
    logic [REG_AW-1:0] rx, ry;
    logic [3:0]        sel;
    logic              mode;
    logic [1:0]        fmt;
    logic [DATA_W-1:0] operand_b, alu_y;
    logic              alu_carry, alu_eq;
    logic              unused_instr;

    // Upper register-field bits wrap away when NUM_REGS < 8.
    assign rx   = instr_q[13 +: REG_AW];
    assign ry   = instr_q[10 +: REG_AW];
    assign sel  = instr_q[6:3];
    assign mode = instr_q[2];
    assign fmt  = instr_q[1:0];
    assign unused_instr = ^instr_q;

`ifdef BITTY_IMM_EN
    assign fmt_legal = (fmt == FMT_REG) || (fmt == FMT_IMM);
    assign operand_b = (fmt == FMT_IMM) ? {{(DATA_W-6){1'b0}}, instr_q[12:7]} : regs_q[ry];
`else
    assign fmt_legal = (fmt == FMT_REG);
    assign operand_b = regs_q[ry];
`endif

    bitty_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a     (s_q),
        .b     (operand_b),
        .sel   (sel),
        .mode  (mode),
        .y     (alu_y),
        .carry (alu_carry),
        .eq    (alu_eq)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StLoad;
            StLoad: state_d = StExec;
            StExec: state_d = StWb;
            StWb:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = (state_q != StIdle);
        accept = (state_q == StIdle) && start;
        ld_ok  = (state_q == StIdle) && ld_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q   <= '0;
            s_q       <= '0;
            c_q       <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_eq_q <= 1'b0;
        end else begin
            if (accept) instr_q <= instr;
            if (state_q == StLoad) s_q <= regs_q[rx];
            if (state_q == StExec) begin
                c_q <= alu_y;
                // Illegal ops must leave the visible flags untouched.
                if (fmt_legal) begin
                    flag_c_q  <= alu_carry;
                    flag_z_q  <= (alu_y == '0);
                    flag_eq_q <= alu_eq;
                end
            end
            done_q <= (state_q == StWb);
            err_q  <= (state_q == StWb) && !fmt_legal;
        end
    end

    // Loads are only honoured in IDLE, so they never collide with a writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
        end else begin
            if (ld_ok) regs_q[ld_addr] <= ld_data;
            if ((state_q == StWb) && fmt_legal) regs_q[rx] <= c_q;
        end
    end

    assign done    = done_q;
    assign err     = err_q;
    assign flag_c  = flag_c_q;
    assign flag_z  = flag_z_q;
    assign flag_eq = flag_eq_q;
    assign rd_data = regs_q[rd_addr];

endmodule
